// File: rtl/sonar_responder.sv
//------------------------------------------------------------------------------
// sonar_responder -- ultrasonic range-sensor emulator (trigger in, echo out).
// Option macro: SONAR_TIMEOUT_EN (out-of-range targets produce a timeout echo).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sonar_responder #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TRIG_MIN_CYC   = 500,
  parameter int ECHO_DELAY_CYC = 25_000,
  parameter int CYC_PER_CM     = 2_900,
  parameter int MAX_CM         = 400,
  parameter int HOLDOFF_CYC    = 3_000_000,
  parameter int TIMEOUT_CYC    = 1_900_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic [7:0] meas_cnt
);

  localparam logic [21:0] C_TRIG_MIN = 22'(TRIG_MIN_CYC);
  localparam logic [21:0] C_DELAY    = 22'(ECHO_DELAY_CYC);
  localparam logic [21:0] C_CPC      = 22'(CYC_PER_CM);
  localparam logic [9:0]  C_MAX_CM   = 10'(MAX_CM);
  localparam logic [21:0] C_HOLDOFF  = 22'(HOLDOFF_CYC);
  localparam logic [21:0] C_TIMEOUT  = 22'(TIMEOUT_CYC);

  // Every timer and the width product must fit the 22-bit counter.
  if (CLK_HZ <= 0 || TRIG_MIN_CYC < 1 || ECHO_DELAY_CYC < 1 || CYC_PER_CM < 1 ||
      MAX_CM < 1 || MAX_CM > 511 || HOLDOFF_CYC < 1 || TIMEOUT_CYC < 1 ||
      longint'(MAX_CM) * longint'(CYC_PER_CM) >= (longint'(1) << 22) ||
      TIMEOUT_CYC >= (1 << 22) || HOLDOFF_CYC >= (1 << 22) ||
      ECHO_DELAY_CYC >= (1 << 22)) begin : g_param_check
    $error("sonar_responder: parameter out of supported range");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t      state;
  logic        sync1;
  logic        trig_s;
  logic        trig_p;
  logic        armed;
  logic [1:0]  settle;
  logic [21:0] cnt;
  logic [8:0]  dist_lat;

  logic        in_range;
  logic [21:0] width;
  logic [21:0] echo_len;
  logic        go_echo;

  always_comb begin
    in_range = (dist_lat != 9'd0) && ({1'b0, dist_lat} <= C_MAX_CM);
    width    = {13'd0, dist_lat} * C_CPC;
`ifdef SONAR_TIMEOUT_EN
    echo_len = in_range ? width : C_TIMEOUT;
    go_echo  = 1'b1;
`else
    echo_len = width;
    go_echo  = in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sync1    <= 1'b0;
      trig_s   <= 1'b0;
      trig_p   <= 1'b0;
      armed    <= 1'b0;
      settle   <= 2'd0;
      cnt      <= 22'd0;
      dist_lat <= 9'd0;
      echo     <= 1'b0;
      busy     <= 1'b0;
      meas_cnt <= 8'd0;
    end else begin
      sync1  <= trigger;
      trig_s <= sync1;
      trig_p <= trig_s;

      // The synchronizer is cleared by reset, so a trigger held high through
      // reset would look like a new edge; arm only once it is really seen low.
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end else if (!trig_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (armed && trig_s && !trig_p) begin
            state <= TRIG;
            busy  <= 1'b1;
            cnt   <= 22'd1;
          end
        end
        TRIG: begin
          if (trig_s) begin
            if (cnt < C_TRIG_MIN) cnt <= cnt + 22'd1;
          end else if (cnt >= C_TRIG_MIN) begin
            state    <= DELAY;
            dist_lat <= dist_cm;
            meas_cnt <= meas_cnt + 8'd1;
            cnt      <= 22'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 22'd0;
          end
        end
        DELAY: begin
          if (cnt == C_DELAY - 22'd1) begin
            cnt <= 22'd0;
            if (go_echo) begin
              state <= ECHO;
              echo  <= 1'b1;
            end else begin
              state <= HOLDOFF;
            end
          end else begin
            cnt <= cnt + 22'd1;
          end
        end
        ECHO: begin
          if (cnt == echo_len - 22'd1) begin
            state <= HOLDOFF;
            echo  <= 1'b0;
            cnt   <= 22'd0;
          end else begin
            cnt <= cnt + 22'd1;
          end
        end
        HOLDOFF: begin
          if (cnt == C_HOLDOFF - 22'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 22'd0;
          end else begin
            cnt <= cnt + 22'd1;
          end
        end
        default: begin
          state <= IDLE;
          echo  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= 22'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonar_responder.sv
//------------------------------------------------------------------------------
// tb_sonar_responder -- directed table-driven bench with scaled-down timers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sonar_responder;

  localparam int TMIN = 8;
  localparam int ED   = 40;
  localparam int CPC  = 4;
  localparam int MAXC = 400;
  localparam int HO   = 60;
  localparam int TO   = 90;
  localparam int R    = ED + 3;   // echo rise, in cycles after trigger fall
  localparam int BUDGET = 4000;

`ifdef SONAR_TIMEOUT_EN
  localparam int OOR_R = R;
  localparam int OOR_W = TO;
`else
  localparam int OOR_R = -1;
  localparam int OOR_W = 0;
`endif

  logic       clk;
  logic       reset;
  logic       trigger;
  logic [8:0] dist_cm;
  logic       echo;
  logic       busy;
  logic [7:0] meas_cnt;

  int errors = 0;
  int checks = 0;

  sonar_responder #(
    .CLK_HZ(50_000_000), .TRIG_MIN_CYC(TMIN), .ECHO_DELAY_CYC(ED),
    .CYC_PER_CM(CPC), .MAX_CM(MAXC), .HOLDOFF_CYC(HO), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .dist_cm(dist_cm),
    .echo(echo), .busy(busy), .meas_cnt(meas_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [8:0] d;
    logic [8:0] alt;   // dist_cm applied once echo rises
    int         rise;
    int         width;
    int         bfall;
    int         meas;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bounded wait (at negedges) for echo (sel=0) or busy (sel=1) to reach lvl.
  task automatic wait_for(input bit sel, input bit lvl, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < BUDGET && !ok; k++) begin
      @(negedge clk);
      if ((sel ? busy : echo) == lvl) ok = 1'b1;
    end
    if (!ok) chk(name, 0, 1);
  endtask

  // Called at a negedge; raises trigger for len cycles, then watches outputs.
  task automatic run_pulse(input int len, input logic [8:0] d, input logic [8:0] alt,
                           output int rise, output int width, output int bfall);
    bit done;
    rise  = -1;
    width = 0;
    bfall = -1;
    done  = 1'b0;
    dist_cm = d;
    trigger = 1'b1;
    repeat (len) @(negedge clk);
    trigger = 1'b0;
    for (int k = 1; k <= BUDGET && !done; k++) begin
      @(negedge clk);
      if (echo) begin
        if (rise < 0) begin
          rise = k;
          dist_cm = alt;
        end
        width++;
      end
      if (!busy) begin
        bfall = k;
        done  = 1'b1;
      end
    end
  endtask

  initial begin
    int  rise, width, bfall;
    bit  stayed;

    vecs[0] = '{12, 9'd5,   9'd100, R,     20,    R + 20 + HO,    1};
    vecs[1] = '{7,  9'd5,   9'd5,   -1,    0,     3,              1};
    vecs[2] = '{8,  9'd1,   9'd1,   R,     4,     R + 4 + HO,     2};
    vecs[3] = '{12, 9'd400, 9'd400, R,     1600,  R + 1600 + HO,  3};
    vecs[4] = '{12, 9'd401, 9'd401, OOR_R, OOR_W, R + OOR_W + HO, 4};
    vecs[5] = '{12, 9'd0,   9'd0,   OOR_R, OOR_W, R + OOR_W + HO, 5};
    vecs[6] = '{30, 9'd17,  9'd3,   R,     68,    R + 68 + HO,    6};

    reset   = 1'b1;
    trigger = 1'b0;
    dist_cm = 9'd0;
    repeat (3) @(negedge clk);
    chk("reset_echo", int'(echo), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_meas", int'(meas_cnt), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_pulse(vecs[i].len, vecs[i].d, vecs[i].alt, rise, width, bfall);
      chk($sformatf("v%0d_rise", i),  rise,  vecs[i].rise);
      chk($sformatf("v%0d_width", i), width, vecs[i].width);
      chk($sformatf("v%0d_busy", i),  bfall, vecs[i].bfall);
      chk($sformatf("v%0d_meas", i),  int'(meas_cnt), vecs[i].meas);
      repeat (5) @(negedge clk);
    end

    // Triggers during ECHO and HOLDOFF, and a level held into IDLE, are ignored.
    dist_cm = 9'd5;
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    wait_for(1'b0, 1'b1, "ign_wait_echo");
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    wait_for(1'b0, 1'b0, "ign_wait_echo_low");
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    trigger = 1'b1;
    wait_for(1'b1, 1'b0, "ign_wait_idle");
    stayed = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) stayed = 1'b0;
    end
    chk("ign_held_level", int'(stayed), 1);
    chk("ign_meas", int'(meas_cnt), 7);
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    run_pulse(12, 9'd5, 9'd5, rise, width, bfall);
    chk("after_rise", rise, R);
    chk("after_width", width, 20);
    chk("after_busy", bfall, R + 20 + HO);
    chk("after_meas", int'(meas_cnt), 8);
    repeat (5) @(negedge clk);

    // One-cycle reset mid-ECHO with trigger held high.
    dist_cm = 9'd50;
    trigger = 1'b1;
    repeat (12) @(negedge clk);
    trigger = 1'b0;
    wait_for(1'b0, 1'b1, "rst_wait_echo");
    repeat (10) @(negedge clk);
    trigger = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_meas", int'(meas_cnt), 0);
    stayed = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy) stayed = 1'b0;
    end
    trigger = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy) stayed = 1'b0;
    end
    chk("rst_no_restart", int'(stayed), 1);
    run_pulse(12, 9'd5, 9'd5, rise, width, bfall);
    chk("rst_new_rise", rise, R);
    chk("rst_new_width", width, 20);
    chk("rst_new_busy", bfall, R + 20 + HO);
    chk("rst_new_meas", int'(meas_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
